// File: rtl/dcnn_s0_wdconv_if.sv
// ---------------------------------------------------------------------------
// dcnn_s0_wdconv_if : per-channel word-in / lane-out handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dcnn_s0_wdconv_if #(
  parameter int NCH   = 2,
  parameter int DW    = 32,
  parameter int RATIO = 2,
  parameter int DEPTH = 4
);
  localparam int IW  = DW * RATIO;
  localparam int NLW = $clog2(RATIO) + 1;
  localparam int LVW = $clog2(DEPTH + 1);

  logic [IW-1:0]  in_data    [NCH];
  logic [NLW-1:0] in_nlanes  [NCH];
  logic           in_vld     [NCH];
  logic           in_rdy     [NCH];
  logic [DW-1:0]  out_data   [NCH];
  logic           out_vld    [NCH];
  logic           out_rdy    [NCH];
  logic           out_last   [NCH];
  logic [LVW-1:0] fifo_level [NCH];
  logic           err_zero   [NCH];

  modport master (
    output in_data, in_nlanes, in_vld, out_rdy,
    input  in_rdy, out_data, out_vld, out_last, fifo_level, err_zero
  );

  modport slave (
    input  in_data, in_nlanes, in_vld, out_rdy,
    output in_rdy, out_data, out_vld, out_last, fifo_level, err_zero
  );
endinterface

`default_nettype wire

// File: rtl/dcnn_s0_wdconv.sv
// ---------------------------------------------------------------------------
// dcnn_s0_wdconv : multi-channel word-to-lane width converter with input FIFO
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcnn_s0_wdconv #(
  parameter int NCH   = 2,
  parameter int DW    = 32,
  parameter int RATIO = 2,
  parameter int DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         cfg_msb_first,
  dcnn_s0_wdconv_if.slave   bus
);
  localparam int IW  = DW * RATIO;
  localparam int NLW = $clog2(RATIO) + 1;
  localparam int LVW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(RATIO);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [IW-1:0]  data_mem [DEPTH];
    logic [NLW-1:0] nl_mem   [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LVW-1:0] level;
    logic [CW-1:0]  cnt;
    logic           mode_q;
    logic           err_q;

    logic           rdy, push, zero_word, vld, xfer, pop, last, mode_eff;
    logic [NLW-1:0] nl_wr, nl_head, rev_idx;
    logic [CW-1:0]  lane_idx;
    logic [IW-1:0]  head_word;
    logic [DW-1:0]  lane;

    assign rdy       = !rst && (level != LVW'(DEPTH));
    assign push      = bus.in_vld[i] && rdy && (bus.in_nlanes[i] != '0);
    assign zero_word = bus.in_vld[i] && rdy && (bus.in_nlanes[i] == '0);
    assign nl_wr     = (bus.in_nlanes[i] > NLW'(RATIO)) ? NLW'(RATIO) : bus.in_nlanes[i];

    assign vld       = (level != '0);
    assign head_word = data_mem[rd_ptr];
    assign nl_head   = nl_mem[rd_ptr];

    // The first lane follows the live config; later lanes reuse what was captured with it.
    assign mode_eff  = (cnt == '0) ? cfg_msb_first : mode_q;
    assign rev_idx   = nl_head - NLW'(1) - NLW'(cnt);
    assign lane_idx  = mode_eff ? rev_idx[CW-1:0] : cnt;
    assign last      = (NLW'(cnt) == (nl_head - NLW'(1)));
    assign xfer      = vld && bus.out_rdy[i];
    assign pop       = xfer && last;

    always_comb begin
      lane = '0;
      for (int k = 0; k < RATIO; k++) begin
        if (lane_idx == CW'(k)) lane = head_word[k*DW +: DW];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        cnt    <= '0;
        mode_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + LVW'(1);
          2'b01:   level <= level - LVW'(1);
          default: level <= level;
        endcase
        if (zero_word) err_q <= 1'b1;
        if (cnt == '0) mode_q <= cfg_msb_first;
        if (pop)       cnt <= '0;
        else if (xfer) cnt <= cnt + CW'(1);
      end
    end

    // Storage is not reset; pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
      if (push) begin
        data_mem[wr_ptr] <= bus.in_data[i];
        nl_mem[wr_ptr]   <= nl_wr;
      end
    end

    assign bus.in_rdy[i]     = rdy;
    assign bus.out_vld[i]    = vld;
    assign bus.out_data[i]   = vld ? lane : '0;
    assign bus.out_last[i]   = vld && last;
    assign bus.fifo_level[i] = level;
    assign bus.err_zero[i]   = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_dcnn_s0_wdconv.sv
// ---------------------------------------------------------------------------
// tb_dcnn_s0_wdconv : checks two converter instances (RATIO 2 and 4) against a word-queue model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcnn_s0_wdconv;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg = 1'b0;
  always #5 clk = ~clk;

  dcnn_s0_wdconv_if #(.NCH(2), .DW(32), .RATIO(2), .DEPTH(DEPTH)) ia ();
  dcnn_s0_wdconv_if #(.NCH(2), .DW(32), .RATIO(4), .DEPTH(DEPTH)) ib ();

  dcnn_s0_wdconv #(.NCH(2), .DW(32), .RATIO(2), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .cfg_msb_first(cfg), .bus(ia));
  dcnn_s0_wdconv #(.NCH(2), .DW(32), .RATIO(4), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .cfg_msb_first(cfg), .bus(ib));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: per stream (A ch0, A ch1, B ch0, B ch1) a queue of words and the lane position in the head.
  logic [127:0] mdat [4][8];
  int           mnl  [4][8];
  int           mhd  [4];
  int           mcnt [4];
  int           mpos [4];
  bit           mmode[4];
  bit           merr [4];

  task automatic chk(string nm, int m, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s stream%0d t=%0t: got %0h expected %0h", nm, m, $time, act, exp);
    end
  endtask

  task automatic model_step(int m, int ratio, logic [31:0] od, logic ov, logic ol, logic ir,
                            logic [2:0] lvl, logic ez, logic iv, logic [127:0] idat, int inl,
                            logic ordy);
    bit ev, er, mode, lst;
    int n, idx;
    logic [127:0] w;
    logic [31:0]  el;
    ev = (mcnt[m] != 0);
    er = !rst && (mcnt[m] != DEPTH);
    el = '0;
    lst = 1'b0;
    if (ev) begin
      w    = mdat[m][mhd[m]];
      n    = mnl[m][mhd[m]];
      mode = (mpos[m] == 0) ? cfg : mmode[m];
      idx  = mode ? (n - 1 - mpos[m]) : mpos[m];
      el   = w[32*idx +: 32];
      lst  = (mpos[m] == n - 1);
    end
    chk("out_vld",    m, 128'(ov),  128'(ev));
    chk("in_rdy",     m, 128'(ir),  128'(er));
    chk("fifo_level", m, 128'(lvl), 128'(mcnt[m]));
    chk("err_zero",   m, 128'(ez),  128'(merr[m]));
    chk("out_data",   m, 128'(od),  128'(el));
    chk("out_last",   m, 128'(ol),  128'(lst));
    if (rst) begin
      mhd[m] = 0; mcnt[m] = 0; mpos[m] = 0; mmode[m] = 1'b0; merr[m] = 1'b0;
    end else begin
      if (ev && ordy) begin
        if (mpos[m] == 0) mmode[m] = cfg;
        if (lst) begin
          mhd[m] = (mhd[m] + 1) % 8; mcnt[m]--; mpos[m] = 0;
        end else begin
          mpos[m]++;
        end
      end
      if (iv && er) begin
        if (inl == 0) merr[m] = 1'b1;
        else begin
          mdat[m][(mhd[m] + mcnt[m]) % 8] = idat;
          mnl[m][(mhd[m] + mcnt[m]) % 8]  = (inl > ratio) ? ratio : inl;
          mcnt[m]++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        model_step(c, 2, ia.out_data[c], ia.out_vld[c], ia.out_last[c], ia.in_rdy[c],
                   ia.fifo_level[c], ia.err_zero[c], ia.in_vld[c], 128'(ia.in_data[c]),
                   int'(ia.in_nlanes[c]), ia.out_rdy[c]);
        model_step(2 + c, 4, ib.out_data[c], ib.out_vld[c], ib.out_last[c], ib.in_rdy[c],
                   ib.fifo_level[c], ib.err_zero[c], ib.in_vld[c], ib.in_data[c],
                   int'(ib.in_nlanes[c]), ib.out_rdy[c]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push_a(int ch, logic [63:0] d, int nl);
    bit acc = 1'b0;
    ia.in_data[ch] = d; ia.in_nlanes[ch] = 2'(nl); ia.in_vld[ch] = 1'b1;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk); acc = ia.in_rdy[ch];
      tick();
    end
    ia.in_vld[ch] = 1'b0;
    if (!acc) begin n_chk++; n_fail++; $display("FAIL push_a_timeout ch%0d got no in_rdy expected in_rdy", ch); end
  endtask

  task automatic push_b(int ch, logic [127:0] d, int nl);
    bit acc = 1'b0;
    ib.in_data[ch] = d; ib.in_nlanes[ch] = 3'(nl); ib.in_vld[ch] = 1'b1;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk); acc = ib.in_rdy[ch];
      tick();
    end
    ib.in_vld[ch] = 1'b0;
    if (!acc) begin n_chk++; n_fail++; $display("FAIL push_b_timeout ch%0d got no in_rdy expected in_rdy", ch); end
  endtask

  initial begin
    int lanes;
    for (int c = 0; c < 2; c++) begin
      ia.in_vld[c] = 1'b0; ia.in_data[c] = '0; ia.in_nlanes[c] = '0; ia.out_rdy[c] = 1'b1;
      ib.in_vld[c] = 1'b0; ib.in_data[c] = '0; ib.in_nlanes[c] = '0; ib.out_rdy[c] = 1'b1;
    end
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_rdy", 0, 128'(ia.in_rdy[0]), 128'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy",  0, 128'(ia.in_rdy[0]),     128'(1));
    chk("post_rst_out_vld", 0, 128'(ia.out_vld[0]),    128'(0));
    chk("post_rst_level",   0, 128'(ia.fifo_level[0]), 128'(0));
    tick();

    // Two-lane word, lane 0 first, one cycle after acceptance.
    push_a(0, 64'hBBBB_BBBB_AAAA_AAAA, 2);
    @(negedge clk);
    chk("lsb_lane0", 0, 128'(ia.out_data[0]), 128'(32'hAAAA_AAAA));
    chk("lsb_last0", 0, 128'(ia.out_last[0]), 128'(0));
    @(negedge clk);
    chk("lsb_lane1", 0, 128'(ia.out_data[0]), 128'(32'hBBBB_BBBB));
    chk("lsb_last1", 0, 128'(ia.out_last[0]), 128'(1));
    tick();

    // Three of four lanes, msb first.
    cfg = 1'b1;
    push_b(0, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 3);
    @(negedge clk);
    chk("msb_lane_a", 2, 128'(ib.out_data[0]), 128'(32'h3333_3333));
    @(negedge clk);
    chk("msb_lane_b", 2, 128'(ib.out_data[0]), 128'(32'h2222_2222));
    @(negedge clk);
    chk("msb_lane_c", 2, 128'(ib.out_data[0]), 128'(32'h1111_1111));
    chk("msb_last",   2, 128'(ib.out_last[0]), 128'(1));
    tick();
    cfg = 1'b0;

    // Fill a stalled FIFO, then drain one word; freed slot shows the cycle after the pop.
    ia.out_rdy[1] = 1'b0;
    for (int k = 0; k < 4; k++) push_a(1, {32'(k + 16'h50), 32'(k + 16'h40)}, 2);
    @(negedge clk);
    chk("full_level", 1, 128'(ia.fifo_level[1]), 128'(4));
    chk("full_rdy",   1, 128'(ia.in_rdy[1]),     128'(0));
    tick();
    ia.out_rdy[1] = 1'b1;
    @(negedge clk);
    chk("full_rdy_cnt0", 1, 128'(ia.in_rdy[1]), 128'(0));
    tick();
    ia.in_data[1] = 64'h0000_0099_0000_0088; ia.in_nlanes[1] = 2'd2; ia.in_vld[1] = 1'b1;
    @(negedge clk);
    chk("full_rdy_popcyc", 1, 128'(ia.in_rdy[1]), 128'(0));
    tick();
    ia.out_rdy[1] = 1'b0;
    @(negedge clk);
    chk("freed_rdy",   1, 128'(ia.in_rdy[1]),     128'(1));
    chk("freed_level", 1, 128'(ia.fifo_level[1]), 128'(3));
    tick();
    ia.in_vld[1] = 1'b0;
    ia.out_rdy[1] = 1'b1;
    repeat (12) tick();

    // Zero-lane word flags only its own channel; oversize counts clamp.
    push_a(1, 64'h1234_5678_9ABC_DEF0, 0);
    @(negedge clk);
    chk("zero_err1", 1, 128'(ia.err_zero[1]), 128'(1));
    chk("zero_vld1", 1, 128'(ia.out_vld[1]),  128'(0));
    chk("zero_err0", 0, 128'(ia.err_zero[0]), 128'(0));
    tick();
    push_a(0, 64'hCCCC_0002_CCCC_0001, 3);
    push_b(1, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 7);
    lanes = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (ib.out_vld[1] && ib.out_rdy[1]) lanes++;
    end
    chk("clamp_lanes", 3, 128'(lanes), 128'(4));
    tick();

    // Order change after the first lane only affects the next word.
    push_b(1, {32'h13, 32'h12, 32'h11, 32'h10}, 4);
    push_b(1, {32'h23, 32'h22, 32'h21, 32'h20}, 4);
    cfg = 1'b1;
    @(negedge clk);
    chk("cfg_keep", 3, 128'(ib.out_data[1]), 128'(32'h11));
    repeat (3) @(negedge clk);
    chk("cfg_next", 3, 128'(ib.out_data[1]), 128'(32'h23));
    repeat (6) tick();
    cfg = 1'b0;

    // Reset mid-word with two words buffered.
    ia.out_rdy[0] = 1'b0;
    push_a(0, 64'h0000_00A2_0000_00A1, 2);
    push_a(0, 64'h0000_00B2_0000_00B1, 2);
    ia.out_rdy[0] = 1'b1;
    tick();
    ia.out_rdy[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_vld",   0, 128'(ia.out_vld[0]),    128'(0));
    chk("rst_mid_level", 0, 128'(ia.fifo_level[0]), 128'(0));
    chk("rst_mid_rdy",   0, 128'(ia.in_rdy[0]),     128'(1));
    tick();
    ia.out_rdy[0] = 1'b1;
    repeat (4) tick();
    push_a(0, 64'h0000_00C2_0000_00C1, 2);
    repeat (4) tick();

    // Mixed traffic on all streams, checked by the model.
    for (int t = 0; t < 300; t++) begin
      for (int c = 0; c < 2; c++) begin
        ia.in_vld[c]    = 1'($urandom_range(0, 1));
        ia.in_data[c]   = {$urandom, $urandom};
        ia.in_nlanes[c] = 2'($urandom_range(0, 3));
        ia.out_rdy[c]   = ($urandom_range(0, 3) != 0);
        ib.in_vld[c]    = 1'($urandom_range(0, 1));
        ib.in_data[c]   = {$urandom, $urandom, $urandom, $urandom};
        ib.in_nlanes[c] = 3'($urandom_range(0, 7));
        ib.out_rdy[c]   = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 15) == 0) cfg = ~cfg;
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      ia.in_vld[c] = 1'b0; ia.out_rdy[c] = 1'b1;
      ib.in_vld[c] = 1'b0; ib.out_rdy[c] = 1'b1;
    end
    repeat (30) tick();
    chk("drained_a0", 0, 128'(ia.out_vld[0]), 128'(0));
    chk("drained_b1", 3, 128'(ib.out_vld[1]), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
